psum_accum_ctrl: RTL and testbench

- Sequencer on the write-back side of the PSUM datapath. It pops rows from the output FIFO, reads matching PSUM SRAM rows, applies the per-lane accumulate or ReLU function, and writes results back to PSUM SRAM.
- Sits between ofifo, the single-port PSUM SRAM and the top-level controller. It owns every SRAM access during a write-back pass.

---
 rtl/psum_accum_ctrl_pkg.sv | 25 ++
 rtl/psum_accum_ctrl_alu.sv | 31 +++
 rtl/psum_accum_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_psum_accum_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_ctrl_pkg.sv
// Shared definitions for the PSUM write-back sequencer: default geometry,
// mode encodings and the controller state enumeration.
package psum_accum_ctrl_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int ADDR_W  = 11;
    localparam int LANE_W  = PSUM_BW;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_ACCUM = 2'b01,
        MODE_RELU  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD   = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/psum_accum_ctrl_alu.sv
// Single-lane write-back function: wrapping accumulate, ReLU on the lane MSB,
// or pass-through of the FIFO operand.
module psum_lane_alu
    import psum_accum_ctrl_pkg::*;
#(
    parameter int lane_w = LANE_W
) (
    input  mode_e              mode,
    input  logic [lane_w-1:0]  q,
    input  logic [lane_w-1:0]  f,
    output logic [lane_w-1:0]  r
);

    // Lane result selected by the latched pass mode
    always_comb begin
        r = q;
        case (mode)
            MODE_ACCUM: r = q + f;
            MODE_RELU: begin
                if (q[lane_w-1]) begin
                    r = {lane_w{1'b0}};
                end else begin
                    r = q;
                end
            end
            MODE_LOAD: r = f;
            default:   r = q;
        endcase
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Write-back sequencer: drains ofifo rows into PSUM SRAM, either loading them
// directly or combining them with the stored row (accumulate / ReLU).
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int addr_w  = ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [addr_w-1:0]        base_addr,
    input  logic [addr_w:0]          num_rows,
    output logic                     busy,
    output logic                     done,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_w-1:0]        sram_addr,
    output logic [col*psum_bw-1:0]   sram_d,
    input  logic [col*psum_bw-1:0]   sram_q
);

    localparam int DATA_W = col * psum_bw;
    localparam logic [addr_w:0]   ROW_ZERO  = {(addr_w+1){1'b0}};
    localparam logic [addr_w:0]   ROW_ONE   = {{addr_w{1'b0}}, 1'b1};
    localparam logic [addr_w-1:0] ADDR_ZERO = {addr_w{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e              state_r;
    mode_e               mode_r;
    logic [addr_w-1:0]   base_r;
    logic [addr_w:0]     num_r;
    logic [addr_w:0]     row_r;
    logic [DATA_W-1:0]   hold_r;
    logic                busy_r;
    logic                done_r;

    logic                last_row_s;
    logic                rd_go_s;
    logic [addr_w-1:0]   row_addr_s;
    logic [DATA_W-1:0]   alu_out_s;
    logic                rd_s;
    logic                cen_s;
    logic                wen_s;
    logic [addr_w-1:0]   addr_s;
    logic [DATA_W-1:0]   d_s;

    assign last_row_s = (row_r == (num_r - ROW_ONE));
    assign row_addr_s = base_r + row_r[addr_w-1:0];
    // RELU never waits on the FIFO; ACCUM needs its operand before reading
    assign rd_go_s    = (mode_r == MODE_RELU) || ofifo_valid;

    genvar k;
    generate
        for (k = 0; k < col; k++) begin : gen_lane
            psum_lane_alu #(
                .lane_w (psum_bw)
            ) u_alu (
                .mode (mode_r),
                .q    (sram_q[k*psum_bw +: psum_bw]),
                .f    (hold_r[k*psum_bw +: psum_bw]),
                .r    (alu_out_s[k*psum_bw +: psum_bw])
            );
        end
    endgenerate

    // Pass sequencing, row counter, operand holding register and status flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_LOAD;
            base_r  <= ADDR_ZERO;
            num_r   <= ROW_ZERO;
            row_r   <= ROW_ZERO;
            hold_r  <= DATA_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (mode != MODE_RSVD)) begin
                        mode_r <= mode_e'(mode);
                        base_r <= base_addr;
                        num_r  <= num_rows;
                        row_r  <= ROW_ZERO;
                        if (num_rows == ROW_ZERO) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= (mode == MODE_LOAD) ? ST_LD : ST_RD;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_LD: begin
                    if (ofifo_valid) begin
                        if (last_row_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            row_r <= row_r + ROW_ONE;
                        end
                    end
                end
                ST_RD: begin
                    if (rd_go_s) begin
                        state_r <= ST_WR;
                        if (mode_r == MODE_ACCUM) begin
                            hold_r <= ofifo_out;
                        end
                    end
                end
                ST_WR: begin
                    if (last_row_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        row_r   <= row_r + ROW_ONE;
                        state_r <= ST_RD;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM and FIFO strobes for the current state; idle values when not working
    always_comb begin
        rd_s   = 1'b0;
        cen_s  = 1'b1;
        wen_s  = 1'b1;
        addr_s = ADDR_ZERO;
        d_s    = DATA_ZERO;
        case (state_r)
            ST_LD: begin
                if (ofifo_valid) begin
                    rd_s   = 1'b1;
                    cen_s  = 1'b0;
                    wen_s  = 1'b0;
                    addr_s = row_addr_s;
                    d_s    = ofifo_out;
                end else begin
                    rd_s   = 1'b0;
                    cen_s  = 1'b1;
                end
            end
            ST_RD: begin
                if (rd_go_s) begin
                    rd_s   = (mode_r == MODE_ACCUM);
                    cen_s  = 1'b0;
                    wen_s  = 1'b1;
                    addr_s = row_addr_s;
                end else begin
                    rd_s   = 1'b0;
                    cen_s  = 1'b1;
                end
            end
            ST_WR: begin
                cen_s  = 1'b0;
                wen_s  = 1'b0;
                addr_s = row_addr_s;
                d_s    = alu_out_s;
            end
            default: begin
                rd_s   = 1'b0;
                cen_s  = 1'b1;
            end
        endcase
    end

    // A reset cycle must never write the SRAM or pop the FIFO
    assign ofifo_rd  = rd_s & reset_n;
    assign sram_cen  = cen_s | ~reset_n;
    assign sram_wen  = wen_s | ~reset_n;
    assign sram_addr = addr_s;
    assign sram_d    = d_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench for psum_accum_ctrl: behavioural FIFO and SRAM around the
// DUT, a row-level reference memory, and a monitor checking every SRAM write.
module tb_psum_accum_ctrl;

    localparam int W  = 16;
    localparam int C  = 8;
    localparam int AW = 11;
    localparam int DW = C * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_rows;
    logic          busy, done, ofifo_valid, ofifo_rd, sram_cen, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] ofifo_out, sram_d, sram_q;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int pop_cnt    = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    bit [DW-1:0] ref_mem [0:2047];
    bit [DW-1:0] mem     [0:2047];
    bit [DW-1:0] stim_w  [0:15];
    bit [DW-1:0] fifo_mem[0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          valid_block = 1'b0;

    always #5 clk = ~clk;

    psum_accum_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .base_addr   (base_addr),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .ofifo_valid (ofifo_valid),
        .ofifo_out   (ofifo_out),
        .ofifo_rd    (ofifo_rd),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_d      (sram_d),
        .sram_q      (sram_q)
    );

    // FIFO model: head is visible combinationally, popped on the clock edge
    assign ofifo_valid = (wr_ptr != rd_ptr) && !valid_block;
    assign ofifo_out   = fifo_mem[rd_ptr[5:0]];
    always @(posedge clk) if (ofifo_rd === 1'b1) rd_ptr <= rd_ptr + 1;

    // SRAM model with one-cycle read latency
    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            if (sram_wen === 1'b0) mem[sram_addr] <= sram_d;
            else                   sram_q <= mem[sram_addr];
        end
    end

    function automatic void check_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: counts strobes and pops, compares each SRAM write with the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (reset_n === 1'b1) begin
            if (sram_cen === 1'b0) strobe_cnt++;
            if (ofifo_rd === 1'b1) pop_cnt++;
            if (sram_cen === 1'b0 && sram_wen === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", sram_addr, sram_d);
                end else begin
                    e = exp_q.pop_front();
                    check_w("write_addr", DW'(sram_addr), DW'(e.a));
                    check_w("write_data", sram_d, e.d);
                end
            end
        end
    end

    // Reference row function from the lane rules, using integer arithmetic
    function automatic bit [DW-1:0] lane_fn(input int m, input bit [DW-1:0] q, input bit [DW-1:0] f);
        bit [DW-1:0] r;
        int qs, fs;
        r = '0;
        for (int k = 0; k < C; k++) begin
            qs = $signed(q[k*W +: W]);
            fs = $signed(f[k*W +: W]);
            if (m == 0)      r[k*W +: W] = f[k*W +: W];
            else if (m == 1) r[k*W +: W] = W'(qs + fs);
            else             r[k*W +: W] = (qs < 0) ? '0 : q[k*W +: W];
        end
        return r;
    endfunction

    task automatic model_rows(input int m, input int b, input int n_rows, input int n_model, input bit push);
        logic [AW-1:0] a;
        bit [DW-1:0]   nw;
        wr_t           ent;
        for (int i = 0; i < n_rows; i++) begin
            a = AW'(b + i);
            if (push && m != 2) begin
                fifo_mem[wr_ptr[5:0]] = stim_w[i];
                wr_ptr++;
            end
            if (i < n_model) begin
                nw = lane_fn(m, ref_mem[a], stim_w[i]);
                ent.a = a;
                ent.d = nw;
                exp_q.push_back(ent);
                ref_mem[a] = nw;
            end
        end
    endtask

    task automatic rand_stim();
        for (int i = 0; i < 16; i++) stim_w[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic run_pass(input int m, input int b, input int n, input int stall_at, input int stall_len,
                            input int exp_lat, input int busy_start_at, input bit push);
        int s0, p0, lat;
        model_rows(m, b, n, n, push);
        s0 = strobe_cnt;
        p0 = pop_cnt;
        @(posedge clk); #1;
        start = 1'b1; mode = 2'(m); base_addr = AW'(b); num_rows = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (lat < 300) begin
            valid_block = (lat >= stall_at) && (lat < stall_at + stall_len);
            start = (lat == busy_start_at);
            if (start) begin
                mode = 2'b00; base_addr = AW'(b + 7); num_rows = 12'd1;
            end
            @(negedge clk);
            if (lat == 1 && n > 0) check_i("busy_first_cycle", int'(busy), 1);
            if (done === 1'b1) break;
            @(posedge clk); #1;
            lat++;
        end
        valid_block = 1'b0;
        start = 1'b0;
        check_i("done_seen", int'(done), 1);
        check_i("busy_at_done", int'(busy), 0);
        if (exp_lat >= 0) check_i("done_latency", lat, exp_lat);
        @(posedge clk); #1;
        @(negedge clk);
        check_i("done_one_cycle", int'(done), 0);
        check_i("strobe_count", strobe_cnt - s0, (m == 0) ? n : 2 * n);
        check_i("pop_count", pop_cnt - p0, (m == 2) ? 0 : n);
        check_i("writes_drained", exp_q.size(), 0);
        check_i("fifo_drained", wr_ptr - rd_ptr, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, m, n, mm;
        reset_n = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0; num_rows = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_done", int'(done), 0);
        check_i("rst_ofifo_rd", int'(ofifo_rd), 0);
        check_i("rst_cen", int'(sram_cen), 1);
        check_i("rst_wen", int'(sram_wen), 1);
        check_w("rst_addr", DW'(sram_addr), '0);
        check_w("rst_d", sram_d, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // LOAD then ACCUM with wrapping lane0
        rand_stim();
        stim_w[0][15:0] = 16'd5; stim_w[1][15:0] = 16'd6; stim_w[2][15:0] = 16'd7;
        run_pass(0, 'h010, 3, 0, 0, 4, -1, 1'b1);
        check_w("load_lane0_r0", DW'(mem['h010][15:0]), DW'(16'd5));
        check_w("load_lane0_r2", DW'(mem['h012][15:0]), DW'(16'd7));
        rand_stim();
        stim_w[0][15:0] = 16'hFFF8; stim_w[1][15:0] = 16'h0001; stim_w[2][15:0] = 16'h7FFF;
        run_pass(1, 'h010, 3, 0, 0, 7, -1, 1'b1);
        check_w("accum_lane0_r0", DW'(mem['h010][15:0]), DW'(16'hFFFD));
        check_w("accum_lane0_r1", DW'(mem['h011][15:0]), DW'(16'h0007));
        check_w("accum_lane0_r2", DW'(mem['h012][15:0]), DW'(16'h8006));

        // RELU on a negative and a positive lane3 value
        rand_stim();
        stim_w[0][63:48] = 16'hFFF0; stim_w[1][63:48] = 16'h0004;
        run_pass(0, 'h100, 2, 0, 0, 3, -1, 1'b1);
        run_pass(2, 'h100, 2, 0, 0, 5, -1, 1'b1);
        check_w("relu_lane3_neg", DW'(mem['h100][63:48]), DW'(16'h0000));
        check_w("relu_lane3_pos", DW'(mem['h101][63:48]), DW'(16'h0004));

        // ACCUM with a 3-cycle FIFO gap before row 1 and a start pulse while busy
        rand_stim();
        run_pass(1, 'h010, 3, 3, 3, 10, 4, 1'b1);

        // Zero rows, then reserved mode
        run_pass(1, 'h300, 0, 0, 0, 1, -1, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b11; base_addr = 11'h040; num_rows = 12'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_i("rsvd_busy", int'(busy), 0);
            check_i("rsvd_cen", int'(sram_cen), 1);
            check_i("rsvd_done", int'(done), 0);
            @(posedge clk); #1;
        end

        // Reset during the row-1 write of an ACCUM pass
        rand_stim();
        b = 'h200;
        model_rows(1, b, 3, 1, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b01; base_addr = AW'(b); num_rows = 12'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(negedge clk);
        check_i("rstwr_cen", int'(sram_cen), 1);
        check_i("rstwr_ofifo_rd", int'(ofifo_rd), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_i("rstwr_busy", int'(busy), 0);
        check_i("rstwr_done", int'(done), 0);
        check_i("rstwr_wen", int'(sram_wen), 1);
        check_w("rstwr_addr", DW'(sram_addr), '0);
        check_w("rstwr_d", sram_d, '0);
        check_w("rstwr_row1_untouched", mem[b+1], ref_mem[b+1]);
        check_i("rstwr_writes", exp_q.size(), 0);
        stim_w[0] = stim_w[2];
        run_pass(0, b + 1, 1, 0, 0, 2, -1, 1'b0);

        // Address wrap at the top of the SRAM
        rand_stim();
        run_pass(0, 'h7FF, 2, 0, 0, 3, -1, 1'b1);
        rand_stim();
        run_pass(1, 'h7FF, 2, 0, 0, 5, -1, 1'b1);

        // Randomised passes with random FIFO gaps
        for (int r = 0; r < 10; r++) begin
            rand_stim();
            m = $urandom_range(0, 2);
            n = $urandom_range(1, 6);
            b = $urandom_range(0, 2047);
            run_pass(m, b, n, $urandom_range(1, 8), $urandom_range(0, 3), -1, -1, 1'b1);
        end

        mm = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] != ref_mem[i]) mm++;
        check_i("mem_image_mismatches", mm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
